// File: rtl/hv_wdg_reg_scan_pkg.sv
// Shared HV register-bank constants and scan FSM types.
// Consumed by the watchdog register scanner and the bank's CRC helpers.
package hv_wdg_reg_scan_pkg;

   localparam int unsigned REG_AW    = 7;
   localparam int unsigned REG_DW    = 8;
   localparam int unsigned REG_CRC_W = 8;

   localparam logic [7:0]  CRC8_POLY = 8'h07;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_REQ,
      ST_CHECK
   } scan_st_e;

endpackage

// File: rtl/hv_wdg_reg_scan_crc8.sv
// Combinational CRC-8 (poly 0x07, init 0, MSB first, no reflection, no final XOR).
// Shared by the watchdog scanner and the register bank write-CRC checker.
module hv_reg_crc8
   import hv_wdg_reg_scan_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic [DW-1:0] i_data,
   output logic [7:0]    o_crc
);

   always_comb begin
      o_crc = '0;
      for (int unsigned i = 0; i < DW; i++) begin
         if (o_crc[7] ^ i_data[DW-1-i]) begin
            o_crc = {o_crc[6:0], 1'b0} ^ CRC8_POLY;
         end else begin
            o_crc = {o_crc[6:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/hv_wdg_reg_scan.sv
// Background HV register-bank integrity scanner: walks an address window through
// the access controller's watchdog read port and reports sticky CRC/timeout faults.
module hv_wdg_reg_scan #(
   parameter int unsigned       REG_AW          = hv_wdg_reg_scan_pkg::REG_AW,
   parameter int unsigned       REG_DW          = hv_wdg_reg_scan_pkg::REG_DW,
   parameter int unsigned       REG_CRC_W       = hv_wdg_reg_scan_pkg::REG_CRC_W,
   parameter logic [REG_AW-1:0] SCAN_START_ADDR = '0,
   parameter logic [REG_AW-1:0] SCAN_END_ADDR   = 7'h3F,
   parameter int unsigned       SCAN_INTV_CYC   = 1000,
   parameter int unsigned       ACK_TO_CYC      = 64
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_scan_en,
   input  logic                 i_err_clr,
   output logic                 o_wdg_scan_rac_rd_req,
   output logic [REG_AW-1:0]    o_wdg_scan_rac_addr,
   input  logic                 i_rac_wdg_scan_ack,
   input  logic [REG_DW-1:0]    i_rac_wdg_scan_data,
   input  logic [REG_CRC_W-1:0] i_rac_wdg_scan_crc,
   output logic                 o_scan_crc_err,
   output logic                 o_scan_to_err,
   output logic [REG_AW-1:0]    o_scan_err_addr,
   output logic                 o_scan_done,
   output logic                 o_scan_busy
);

   import hv_wdg_reg_scan_pkg::*;

   localparam int unsigned      CNT_MAX   = (SCAN_INTV_CYC > ACK_TO_CYC) ? SCAN_INTV_CYC : ACK_TO_CYC;
   localparam int unsigned      CNT_W     = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INTV_LAST = CNT_W'(SCAN_INTV_CYC - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ACK_TO_CYC - 1);

   scan_st_e               r_state, w_state_nxt;
   logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
   logic [REG_AW-1:0]      r_addr, w_addr_nxt;
   logic [REG_AW-1:0]      r_err_addr, w_err_addr_nxt;
   logic [REG_DW-1:0]      r_cap_data;
   logic [REG_CRC_W-1:0]   r_cap_crc;
   logic                   r_req, w_req_nxt;
   logic                   r_busy, w_busy_nxt;
   logic                   r_done, w_done_nxt;
   logic                   r_crc_err, w_crc_err_nxt;
   logic                   r_to_err, w_to_err_nxt;
   logic [7:0]             w_calc_crc;
   logic                   w_last, w_ack_ok, w_to_hit, w_crc_ev, w_err_ev, w_adv;

   hv_reg_crc8 #(.DW(REG_DW)) u_crc8 (
      .i_data (r_cap_data),
      .o_crc  (w_calc_crc)
   );

   // Disable overrides everything, so no event qualifies while i_scan_en is low.
   assign w_last   = (r_addr == SCAN_END_ADDR);
   assign w_ack_ok = i_scan_en && (r_state == ST_REQ) && i_rac_wdg_scan_ack;
   assign w_to_hit = i_scan_en && (r_state == ST_REQ) && !i_rac_wdg_scan_ack && (r_cnt == TO_LAST);
   assign w_crc_ev = i_scan_en && (r_state == ST_CHECK) && (r_cap_crc != REG_CRC_W'(w_calc_crc));
   assign w_err_ev = w_crc_ev || w_to_hit;
   assign w_adv    = w_to_hit || (i_scan_en && (r_state == ST_CHECK));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!i_scan_en) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  w_state_nxt = ST_WAIT;
            ST_WAIT:  if (r_cnt == INTV_LAST) w_state_nxt = ST_REQ;
            ST_REQ: begin
               if (w_ack_ok) begin
                  w_state_nxt = ST_CHECK;
               end else if (w_to_hit) begin
                  w_state_nxt = w_last ? ST_WAIT : ST_REQ;
               end
            end
            ST_CHECK: w_state_nxt = w_last ? ST_WAIT : ST_REQ;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_req_nxt  = (w_state_nxt == ST_REQ);
      w_busy_nxt = (w_state_nxt == ST_REQ) || (w_state_nxt == ST_CHECK);
      w_done_nxt = w_adv && w_last;

      // Timeout-to-next-address stays in REQ, so the advance must also restart the count.
      if ((w_state_nxt != r_state) || w_adv || ((r_state != ST_WAIT) && (r_state != ST_REQ))) begin
         w_cnt_nxt = '0;
      end else begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end

      if (!i_scan_en) begin
         w_addr_nxt = SCAN_START_ADDR;
      end else if (w_adv) begin
         w_addr_nxt = w_last ? SCAN_START_ADDR : r_addr + REG_AW'(1);
      end else begin
         w_addr_nxt = r_addr;
      end

      w_crc_err_nxt  = r_crc_err;
      w_to_err_nxt   = r_to_err;
      w_err_addr_nxt = r_err_addr;
      if (i_err_clr) begin
         w_crc_err_nxt  = w_crc_ev;
         w_to_err_nxt   = w_to_hit;
         w_err_addr_nxt = w_err_ev ? r_addr : '0;
      end else begin
         if (w_err_ev && !r_crc_err && !r_to_err) w_err_addr_nxt = r_addr;
         w_crc_err_nxt = r_crc_err | w_crc_ev;
         w_to_err_nxt  = r_to_err  | w_to_hit;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt      <= '0;
         r_addr     <= SCAN_START_ADDR;
         r_req      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_crc_err  <= 1'b0;
         r_to_err   <= 1'b0;
         r_err_addr <= '0;
         r_cap_data <= '0;
         r_cap_crc  <= '0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_addr     <= w_addr_nxt;
         r_req      <= w_req_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_crc_err  <= w_crc_err_nxt;
         r_to_err   <= w_to_err_nxt;
         r_err_addr <= w_err_addr_nxt;
         if (w_ack_ok) begin
            r_cap_data <= i_rac_wdg_scan_data;
            r_cap_crc  <= i_rac_wdg_scan_crc;
         end
      end
   end

   assign o_wdg_scan_rac_rd_req = r_req;
   assign o_wdg_scan_rac_addr   = r_addr;
   assign o_scan_crc_err        = r_crc_err;
   assign o_scan_to_err         = r_to_err;
   assign o_scan_err_addr       = r_err_addr;
   assign o_scan_done           = r_done;
   assign o_scan_busy           = r_busy;

endmodule

// File: tb/tb_hv_wdg_reg_scan.sv
// Self-checking bench for hv_wdg_reg_scan: access-controller responder, reference
// model compared every cycle, plus directed literal checks from the test plan.
module tb_hv_wdg_reg_scan;

   localparam int unsigned AW     = 7;
   localparam int unsigned DW     = 8;
   localparam int unsigned CW     = 8;
   localparam int unsigned START  = 0;
   localparam int unsigned END_A  = 2;
   localparam int unsigned INTV   = 4;
   localparam int unsigned ACK_TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          scan_en = 1'b0;
   logic          err_clr = 1'b0;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rac_ack;
   logic [DW-1:0] rac_data = '0;
   logic [CW-1:0] rac_crc = '0;
   logic          crc_err, to_err, done, busy;
   logic [AW-1:0] err_addr;
   logic          auto_ack = 1'b0;
   logic          inj_ack = 1'b0;

   assign rac_ack = auto_ack | inj_ack;

   hv_wdg_reg_scan #(
      .REG_AW          (AW),
      .REG_DW          (DW),
      .REG_CRC_W       (CW),
      .SCAN_START_ADDR (7'(START)),
      .SCAN_END_ADDR   (7'(END_A)),
      .SCAN_INTV_CYC   (INTV),
      .ACK_TO_CYC      (ACK_TO)
   ) u_dut (
      .i_clk                 (clk),
      .i_rst_n               (rst_n),
      .i_scan_en             (scan_en),
      .i_err_clr             (err_clr),
      .o_wdg_scan_rac_rd_req (rd_req),
      .o_wdg_scan_rac_addr   (rd_addr),
      .i_rac_wdg_scan_ack    (rac_ack),
      .i_rac_wdg_scan_data   (rac_data),
      .i_rac_wdg_scan_crc    (rac_crc),
      .o_scan_crc_err        (crc_err),
      .o_scan_to_err         (to_err),
      .o_scan_err_addr       (err_addr),
      .o_scan_done           (done),
      .o_scan_busy           (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // CRC-8 by polynomial long division of data*x^8 by x^8+x^2+x+1.
   function automatic logic [7:0] crc_ref(input logic [7:0] d);
      logic [15:0] r;
      r = {d, 8'h00};
      for (int b = 15; b >= 8; b--) begin
         if (r[b]) r = r ^ (16'h0107 << (b - 8));
      end
      return r[7:0];
   endfunction

   // Register bank / access controller responder.
   logic [7:0] mem_d [0:127];
   logic [7:0] mem_c [0:127];
   bit         noack [0:127];
   int         dly   [0:127];
   int         age = 0;
   logic          p_req = 1'b0;
   logic [AW-1:0] p_addr = '0;
   logic          p_ack = 1'b0;

   always @(posedge clk) begin
      #1;
      if (rd_req && p_req && (rd_addr == p_addr) && !p_ack) age++;
      else age = 0;
      auto_ack = rd_req && !noack[rd_addr] && (age == 3 + dly[rd_addr]);
      rac_data = mem_d[rd_addr];
      rac_crc  = mem_c[rd_addr];
      p_req  = rd_req;
      p_addr = rd_addr;
      p_ack  = auto_ack;
   end

   // Reference model: phase 0 off, 1 interval, 2 reading, 3 checking.
   int   m_ph = 0, m_left = 0, m_age = 0, m_addr = START, m_ea_prev = 0;
   int   m_cd = 0, m_cc = 0;
   bit   m_evc, m_evt, m_adv;
   logic e_req = 0, e_busy = 0, e_done = 0, e_crc = 0, e_to = 0;
   int   e_ea = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph = 0; m_addr = START; m_age = 0; m_left = 0;
         e_req = 0; e_busy = 0; e_done = 0; e_crc = 0; e_to = 0; e_ea = 0;
      end else begin
         m_evc = 0; m_evt = 0; m_adv = 0; e_done = 0;
         if (!scan_en) begin
            m_ph = 0;
            m_addr = START;
         end else begin
            case (m_ph)
               0: begin m_ph = 1; m_left = INTV; end
               1: begin
                  m_left--;
                  if (m_left == 0) begin m_ph = 2; m_age = 0; end
               end
               2: begin
                  if (rac_ack) begin
                     m_cd = rac_data; m_cc = rac_crc; m_ph = 3;
                  end else if (m_age == ACK_TO - 1) begin
                     m_evt = 1; m_adv = 1;
                  end else begin
                     m_age++;
                  end
               end
               default: begin
                  m_evc = (crc_ref(8'(m_cd)) != 8'(m_cc));
                  m_adv = 1;
               end
            endcase
         end
         m_ea_prev = m_addr;
         if (m_adv) begin
            if (m_addr == END_A) begin
               e_done = 1; m_addr = START; m_ph = 1; m_left = INTV;
            end else begin
               m_addr++; m_ph = 2; m_age = 0;
            end
         end
         if (err_clr) begin
            e_crc = m_evc; e_to = m_evt;
            e_ea = (m_evc || m_evt) ? m_ea_prev : 0;
         end else begin
            if ((m_evc || m_evt) && !e_crc && !e_to) e_ea = m_ea_prev;
            e_crc = e_crc | m_evc;
            e_to  = e_to | m_evt;
         end
         e_req  = (m_ph == 2);
         e_busy = (m_ph == 2) || (m_ph == 3);
      end
   end

   always @(negedge clk) begin
      chk("req", rd_req, e_req);
      chk("addr", rd_addr, m_addr);
      chk("crc_err", crc_err, e_crc);
      chk("to_err", to_err, e_to);
      chk("err_addr", err_addr, e_ea);
      chk("done", done, e_done);
      chk("busy", busy, e_busy);
   end

   // Observation counters for directed checks.
   int          run0 = 0, run1 = 0, n_done_mon = 0;
   logic [AW-1:0] ack_q [$];
   always @(negedge clk) begin
      if (auto_ack && rd_req) ack_q.push_back(rd_addr);
      if (rd_req && rd_addr == 0) run0++;
      if (rd_req && rd_addr == 1) run1++;
      if (done) n_done_mon++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string nm);
      bit seen = 0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         seen = done;
      end
      chk({nm, "_bound"}, seen, 1);
   endtask

   task automatic wait_req(input string nm);
      bit seen = 0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         seen = rd_req;
      end
      chk({nm, "_bound"}, seen, 1);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_req"}, rd_req, 0);
      chk({nm, "_addr"}, rd_addr, START);
      chk({nm, "_crc"}, crc_err, 0);
      chk({nm, "_to"}, to_err, 0);
      chk({nm, "_ea"}, err_addr, 0);
      chk({nm, "_done"}, done, 0);
      chk({nm, "_busy"}, busy, 0);
   endtask

   int en_cyc, q0, d0, r0, r1;

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem_d[i] = 8'h00; mem_c[i] = 8'h00; noack[i] = 0; dly[i] = 0;
      end
      mem_d[0] = 8'h01; mem_c[0] = 8'h07;
      mem_d[1] = 8'hFF; mem_c[1] = 8'hF3;
      mem_d[2] = 8'h00; mem_c[2] = 8'h00;

      chk("crc_ref_01", crc_ref(8'h01), 8'h07);
      chk("crc_ref_ff", crc_ref(8'hFF), 8'hF3);

      #1 rst_n = 1'b0;
      #10 chk_reset_vals("rst");
      #1 rst_n = 1'b1;
      tick(); tick();

      // Clean pass
      q0 = ack_q.size(); d0 = n_done_mon;
      scan_en = 1'b1; en_cyc = cyc;
      wait_done("clean_done");
      chk("clean_pass_len", cyc - en_cyc, 1 + INTV + 5 * 3);
      tick();
      chk("clean_ack_cnt", ack_q.size() - q0, 3);
      chk("clean_ack0", ack_q[q0], 0);
      chk("clean_ack1", ack_q[q0 + 1], 1);
      chk("clean_ack2", ack_q[q0 + 2], 2);
      chk("clean_ndone", n_done_mon - d0, 1);
      chk("clean_crc", crc_err, 0);
      chk("clean_to", to_err, 0);
      scan_en = 1'b0;
      tick(); tick();

      // CRC faults at addr 1 then addr 2
      mem_d[1] = 8'h01; mem_c[1] = 8'h06;
      mem_d[2] = 8'h01; mem_c[2] = 8'h06;
      scan_en = 1'b1;
      wait_done("crc_done");
      chk("crc_flag", crc_err, 1);
      chk("crc_ea", err_addr, 1);
      chk("crc_to", to_err, 0);

      // Disable the cycle after req rises, then inject a late ack
      wait_req("dis_rise");
      tick();
      scan_en = 1'b0;
      tick();
      @(negedge clk);
      chk("dis_req_drop", rd_req, 0);
      tick();
      inj_ack = 1'b1;
      tick();
      inj_ack = 1'b0;
      tick();
      chk("dis_keep_crc", crc_err, 1);
      chk("dis_keep_ea", err_addr, 1);
      chk("dis_keep_to", to_err, 0);
      chk("dis_busy", busy, 0);
      tick();
      scan_en = 1'b1; en_cyc = cyc;
      wait_req("reen_rise");
      chk("reen_delay", cyc - en_cyc, 1 + INTV);
      chk("reen_addr", rd_addr, START);
      wait_done("reen_done");
      chk("reen_ea", err_addr, 1);
      scan_en = 1'b0;
      tick();

      // Clear sticky errors
      mem_d[1] = 8'hFF; mem_c[1] = 8'hF3;
      mem_d[2] = 8'h00; mem_c[2] = 8'h00;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      @(negedge clk);
      chk("clr_crc", crc_err, 0);
      chk("clr_to", to_err, 0);
      chk("clr_ea", err_addr, 0);

      // Timeout on addr 0
      noack[0] = 1;
      tick();
      r0 = run0; q0 = ack_q.size();
      scan_en = 1'b1;
      wait_done("to_done");
      tick();
      chk("to_req_len", run0 - r0, ACK_TO);
      chk("to_flag", to_err, 1);
      chk("to_ea", err_addr, 0);
      chk("to_crc", crc_err, 0);
      chk("to_next_addr", ack_q[q0], 1);
      scan_en = 1'b0;
      noack[0] = 0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      tick();

      // Controller held by SPI for 10 cycles on addr 1
      dly[1] = 10;
      r1 = run1;
      scan_en = 1'b1;
      wait_done("cont_done");
      tick();
      chk("cont_req_len", run1 - r1, 14);
      chk("cont_to", to_err, 0);
      chk("cont_crc", crc_err, 0);
      scan_en = 1'b0;
      dly[1] = 0;
      tick();

      // Asynchronous reset while a request is outstanding
      scan_en = 1'b1;
      wait_req("rst_rise");
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("arst");
      scan_en = 1'b0;
      #1 rst_n = 1'b1;
      tick(); tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/hv_wdg_reg_scan.md
# hv_wdg_reg_scan

Background register-integrity scanner. It periodically walks a fixed address window of the HV register bank through the register access controller's low-priority watchdog-scan read port. For each read it checks the returned CRC against a locally computed CRC and reports sticky CRC-mismatch and ack-timeout faults to the HV watchdog/fault logic.

## Interface
Parameters:
- REG_AW, 7: register address width.
- REG_DW, 8: register data width.
- REG_CRC_W, 8: register CRC width.
- SCAN_START_ADDR, 7'h00: first address scanned.
- SCAN_END_ADDR, 7'h3F: last address scanned, inclusive. Must be >= SCAN_START_ADDR.
- SCAN_INTV_CYC, 1000: idle cycles between passes. Must be >= 1.
- ACK_TO_CYC, 64: maximum cycles from request to ack.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_scan_en  in  1  scan enable, level.
- i_err_clr  in  1  single-cycle pulse; clears sticky errors.
- o_wdg_scan_rac_rd_req  out  1  read request to the access controller.
- o_wdg_scan_rac_addr  out  REG_AW  read address.
- i_rac_wdg_scan_ack  in  1  read ack, single cycle.
- i_rac_wdg_scan_data  in  REG_DW  read data, valid with ack.
- i_rac_wdg_scan_crc  in  REG_CRC_W  stored CRC, valid with ack.
- o_scan_crc_err  out  1  sticky CRC mismatch.
- o_scan_to_err  out  1  sticky ack timeout.
- o_scan_err_addr  out  REG_AW  address of the first error since the last clear.
- o_scan_done  out  1  one-cycle pulse at the end of each full pass.
- o_scan_busy  out  1  high while in REQ or CHECK.

## Operation
The state machine has four states: IDLE, WAIT, REQ, CHECK.
- **IDLE:** entered when i_scan_en=0.
  - Outputs req=0.
  - Address held at SCAN_START_ADDR.
  - Interval counter cleared.
  - Goes to WAIT when i_scan_en=1.
- **WAIT:** counts SCAN_INTV_CYC cycles, then goes to REQ.
- **REQ:** holds req=1 with a stable address until ack or timeout.
  - On ack: captures data and CRC, goes to CHECK.
  - On timeout (counter reaches ACK_TO_CYC with no ack): sets to_err and goes to the next address.
- **CHECK:** one cycle. Compares captured CRC with CRC8(captured data).
  - On mismatch: sets crc_err.
  - Then advances to the next address.
- **Next address:**
  - If the address equals SCAN_END_ADDR: pulse o_scan_done, reload SCAN_START_ADDR, go to WAIT.
  - Otherwise: address+1, go to REQ.
- **CRC8:** poly 0x07, init 0x00, data MSB first, no reflection, no final XOR.
- **o_scan_err_addr:** latched only when both sticky flags are 0 before the event, so it always records the first error.
- **Clear/set collision:** i_err_clr clears both flags and err_addr to 0. If clr coincides with a new error, the error wins: the flag is set and the address is captured.
- **i_scan_en falling:** takes effect at the next clock from any state, including mid-REQ.
  - req drops next cycle; go to IDLE.
  - A late ack arriving after that is ignored.
  - Sticky errors are kept.
- **Ack outside REQ:** ignored.

## Timing
- **Reset values:** req=0, addr=SCAN_START_ADDR, crc_err=0, to_err=0, err_addr=0, done=0, busy=0, state IDLE.
- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Request handshake:**
  - req asserts the cycle after entering REQ.
  - With the controller idle, ack arrives 2 cycles after the controller grants, i.e. 3 cycles after req first appears at the controller.
  - req must stay high through the ack cycle and fall in the cycle after it.
  - A higher-priority SPI access may delay the grant; req and addr stay stable meanwhile.
- **Timeout counter:** starts at 0 on REQ entry. Timeout is declared when the count reaches ACK_TO_CYC-1 with no ack. An ack in that same cycle wins (no timeout).
- **Error flag update:** crc_err/to_err rise in the cycle after CHECK or after the timeout cycle.
- **Pass timing:** with no contention, a pass takes SCAN_INTV_CYC + N×5 cycles, where N = SCAN_END_ADDR−SCAN_START_ADDR+1.
- **Done pulse:** o_scan_done pulses in the cycle after the last CHECK.

## Structure
- Shared package hv_param.svh already carries REG_AW, REG_DW, REG_CRC_W. Add there:
  - CRC8_POLY=8'h07.
  - the scan state enum type scan_st_e.
- Sub-module hv_reg_crc8: combinational, parameter DW, input data, output CRC. Reused by the register bank's write-CRC checker.
- The top level contains the FSM, interval/timeout counter (shared; only one is active per state), address counter, and error capture.

## Test plan
- **Clean pass:** START=0, END=2, INTV=4. Model returns data 0x01/crc 0x07, 0xFF/0xF3, 0x00/0x00. Required: addresses 0,1,2 requested in order; one done pulse; no errors.
- **CRC fault:** addr 1 returns data 0x01/crc 0x06. Required: crc_err=1, err_addr=1. A second fault at addr 2 leaves err_addr at 1. i_err_clr then clears both flags and err_addr.
- **Timeout:** ACK_TO_CYC=8, addr 0 never acked. Required: req high for exactly 8 cycles; to_err=1, err_addr=0; scan continues to addr 1.
- **Contention:** SPI holds the controller 10 cycles during a scan req. Required: req/addr stable, no timeout, correct data captured after grant.
- **Disable mid-read:** i_scan_en drops the cycle after req rises. Required: req=0 next cycle; the late ack is ignored; flags unchanged. Re-enable restarts from SCAN_START_ADDR after INTV.
- **Reset mid-REQ:** assert i_rst_n=0 asynchronously. Required: all outputs go to reset values immediately.
